// File: rtl/uart_fifo_bridge_pkg.sv
// uart_fifo_bridge_pkg: shared register offsets, STATUS bit positions and FSM encodings
package uart_fifo_bridge_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;
    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_FULL  = 3;
    localparam int ST_OVF      = 4;
    localparam int TX_TIMEOUT  = 15;
    typedef enum logic {RX_IDLE, RX_WAIT} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_PULSE, TX_BUSY, TX_DONE} tx_state_e;
endpackage

// File: rtl/uart_fifo_bridge_fifo.sv
// sync_fifo: single-clock FIFO with simultaneous push/pop and occupancy count
//  clk, rst_n      clock, asynchronous active-low reset
//  push, din       write request and data; honoured when not full or when a pop frees a slot
//  pop, dout       read request and head data; ignored when empty
//  full, empty     occupancy flags
//  count           number of stored entries (DEPTH_LOG2+1 bits)
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;
    assign empty   = count_q == '0;
    assign full    = count_q == CW'(DEPTH);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: memory-mapped RX/TX FIFO front end for the UART core with level IRQ
//  cpu_clk, rst_in            clock, asynchronous active-low reset
//  addr, wdata, bus_write     CPU write port (0 DATA, 1 STATUS, 2 CTRL, 3 LEVEL)
//  bus_rd_done, rdata         read-completion strobe (pops RX on DATA) and combinational read data
//  rx_data, rx_new, uart_read core receive byte, level flag and one-cycle ack
//  tx_ready, tx_data, uart_write core transmit handshake
//  irq                        registered level interrupt
module uart_fifo_bridge
    import uart_fifo_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        cpu_clk,
    input  logic        rst_in,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    input  logic        bus_write,
    input  logic        bus_rd_done,
    output logic [15:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_new,
    output logic        uart_read,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        uart_write,
    output logic        irq
);
    rx_state_e           rx_q, rx_d;
    tx_state_e           tx_q, tx_d;
    logic [3:0]          tmr_q, tmr_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic                ovf_q, ovf_d, irq_q, irq_d, uart_read_q, uart_read_d;
    logic                rx_push, rx_pop, rx_full, rx_empty, rx_accept, ovf_set;
    logic                tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]          rx_dout, tx_dout;
    logic [DEPTH_LOG2:0] rx_count, tx_count;
    logic [4:0]          status;
    logic                unused_wdata;
    assign unused_wdata = ^wdata[15:8];
    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk(cpu_clk), .rst_n(rst_in), .push(rx_push), .pop(rx_pop), .din(rx_data),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );
    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk(cpu_clk), .rst_n(rst_in), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );
    assign rx_pop     = bus_rd_done & (addr == REG_DATA);
    assign tx_push    = bus_write & (addr == REG_DATA);
    // A CPU pop in the capture cycle makes room even when RX is full
    assign rx_accept  = ~rx_full | rx_pop;
    assign uart_read  = uart_read_q;
    assign uart_write = tx_q == TX_PULSE;
    assign tx_data    = tx_data_q;
    assign irq        = irq_q;
    always_comb begin
        rx_d        = rx_q;
        rx_push     = 1'b0;
        ovf_set     = 1'b0;
        uart_read_d = 1'b0;
        if (rx_q == RX_IDLE) begin
            if (rx_new) begin
                rx_push     = rx_accept;
                ovf_set     = ~rx_accept;
                uart_read_d = 1'b1;
                rx_d        = RX_WAIT;
            end
        end else if (!rx_new) begin
            rx_d = RX_IDLE;
        end
    end
    always_comb begin
        tx_d      = tx_q;
        tx_pop    = 1'b0;
        tx_data_d = tx_data_q;
        tmr_d     = tmr_q;
        case (tx_q)
            TX_IDLE: begin
                if (!tx_empty && tx_ready) begin
                    tx_data_d = tx_dout;
                    tx_pop    = 1'b1;
                    tx_d      = TX_PULSE;
                end
            end
            TX_PULSE: begin
                tmr_d = '0;
                tx_d  = TX_BUSY;
            end
            TX_BUSY: begin
                // Leave when the core drops ready, or give up after TX_TIMEOUT cycles
                if (!tx_ready || tmr_q == 4'(TX_TIMEOUT - 1)) tx_d = TX_DONE;
                else tmr_d = tmr_q + 4'd1;
            end
            TX_DONE: begin
                if (tx_ready) tx_d = TX_IDLE;
            end
            default: tx_d = TX_IDLE;
        endcase
    end
    always_comb begin
        status              = '0;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_OVF]      = ovf_q;
        ctrl_d = (bus_write && addr == REG_CTRL) ? wdata[1:0] : ctrl_q;
        ovf_d  = ovf_set | (ovf_q & ~(bus_write && addr == REG_STATUS && wdata[ST_OVF]));
        irq_d  = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty) | ovf_q;
        rdata  = addr == REG_DATA   ? {8'h00, rx_empty ? 8'h00 : rx_dout} :
                 addr == REG_STATUS ? {11'b0, status} :
                 addr == REG_CTRL   ? {14'b0, ctrl_q} :
                                      {8'(tx_count), 8'(rx_count)};
    end
    always_ff @(posedge cpu_clk or negedge rst_in) begin
        if (!rst_in) begin
            rx_q        <= RX_IDLE;
            tx_q        <= TX_IDLE;
            tmr_q       <= '0;
            tx_data_q   <= '0;
            ctrl_q      <= '0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
            uart_read_q <= 1'b0;
        end else begin
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            tmr_q       <= tmr_d;
            tx_data_q   <= tx_data_d;
            ctrl_q      <= ctrl_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
            uart_read_q <= uart_read_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: scoreboard bench for uart_fifo_bridge with queue-based reference model
module tb_uart_fifo_bridge;
    import uart_fifo_bridge_pkg::*;
    logic        cpu_clk = 0, rst_in = 0;
    logic [1:0]  addr = 0;
    logic [15:0] wdata = 0;
    logic        bus_write = 0, bus_rd_done = 0;
    logic [15:0] rdata;
    logic [7:0]  rx_data = 0;
    logic        rx_new = 0;
    logic        uart_read, tx_ready, uart_write, irq;
    logic [7:0]  tx_data;
    int          n_cmp = 0, n_bad = 0, cyc = 0, last_wr = -1;
    logic [7:0]  rx_m[$], tx_m[$];
    logic [15:0] rd_exp[$];
    logic        ovf_m = 0, tx_allow = 0, core_drop = 1, timeout_mode = 0;
    logic [1:0]  ctrl_m = 0;

    always #5 cpu_clk = ~cpu_clk;

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .cpu_clk(cpu_clk), .rst_in(rst_in), .addr(addr), .wdata(wdata), .bus_write(bus_write),
        .bus_rd_done(bus_rd_done), .rdata(rdata), .rx_data(rx_data), .rx_new(rx_new),
        .uart_read(uart_read), .tx_ready(tx_ready), .tx_data(tx_data), .uart_write(uart_write), .irq(irq)
    );

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] status_m();
        return {11'b0, ovf_m, tx_m.size() == 16, tx_m.size() == 0, rx_m.size() == 16, rx_m.size() == 0};
    endfunction

    function automatic logic [15:0] level_m();
        return {8'(tx_m.size()), 8'(rx_m.size())};
    endfunction

    function automatic logic irq_m();
        return (ctrl_m[0] && rx_m.size() > 0) || (ctrl_m[1] && tx_m.size() == 0) || ovf_m;
    endfunction

    // Core transmit side: drops tx_ready for 5 cycles after each accepted byte when core_drop is set
    initial begin
        int hold = 0;
        tx_ready = 0;
        forever begin
            @(negedge cpu_clk);
            if (uart_write && core_drop) hold = 5;
            tx_ready = tx_allow && hold == 0;
            if (hold > 0) hold--;
        end
    end

    // Monitor: compares every read completion and every transmit strobe against the scoreboard
    initial begin
        forever begin
            @(negedge cpu_clk);
            cyc++;
            if (rst_in) begin
                if (bus_rd_done) begin
                    if (rd_exp.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL rd_unexpected: got %h expected no read", rdata);
                    end else check("rdata", rdata, rd_exp.pop_front());
                end
                if (uart_write) begin
                    if (tx_m.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL tx_unexpected: got %h expected no strobe", tx_data);
                    end else check("tx_data", {8'h00, tx_data}, {8'h00, tx_m.pop_front()});
                    if (last_wr >= 0) begin
                        // Timeout path: PULSE + 15 BUSY + DONE + IDLE
                        if (timeout_mode) check("tx_spacing_timeout", 16'(cyc - last_wr), 16'(3 + TX_TIMEOUT));
                        else check("tx_spacing_min4", 16'(cyc - last_wr >= 4), 16'd1);
                    end
                    last_wr = cyc;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
        @(posedge cpu_clk); #2;
        addr = a; wdata = d; bus_write = 1;
        if (a == REG_DATA && tx_m.size() < 16) tx_m.push_back(d[7:0]);
        if (a == REG_STATUS && d[4]) ovf_m = 0;
        if (a == REG_CTRL) ctrl_m = d[1:0];
        @(posedge cpu_clk); #2;
        bus_write = 0;
    endtask

    task automatic cpu_read(input logic [1:0] a);
        logic [15:0] e;
        @(posedge cpu_clk); #2;
        e = a == REG_DATA   ? (rx_m.size() > 0 ? {8'h00, rx_m[0]} : 16'h0) :
            a == REG_STATUS ? status_m() :
            a == REG_CTRL   ? {14'b0, ctrl_m} : level_m();
        addr = a; bus_rd_done = 1;
        rd_exp.push_back(e);
        if (a == REG_DATA && rx_m.size() > 0) void'(rx_m.pop_front());
        @(posedge cpu_clk); #2;
        bus_rd_done = 0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic pop_too);
        logic seen = 0;
        @(posedge cpu_clk); #2;
        rx_data = b; rx_new = 1;
        if (pop_too) begin
            addr = REG_DATA; bus_rd_done = 1;
            rd_exp.push_back(rx_m.size() > 0 ? {8'h00, rx_m[0]} : 16'h0);
            if (rx_m.size() > 0) void'(rx_m.pop_front());
        end
        if (rx_m.size() < 16) rx_m.push_back(b);
        else ovf_m = 1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge cpu_clk); #2;
            bus_rd_done = 0;
            seen = uart_read;
        end
        check("uart_read_seen", 16'(seen), 16'd1);
        rx_new = 0;
        @(posedge cpu_clk); #2;
        check("uart_read_one_cycle", 16'(uart_read), 16'd0);
    endtask

    task automatic check_irq();
        @(posedge cpu_clk); #2;
        check("irq", 16'(irq), 16'(irq_m()));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && tx_m.size() > 0; i++) @(negedge cpu_clk);
        check("tx_drained", 16'(tx_m.size()), 16'd0);
        repeat (25) @(posedge cpu_clk);
    endtask

    initial begin
        logic found;
        logic [7:0] hello[3] = '{8'h41, 8'h42, 8'h43};
        repeat (3) @(posedge cpu_clk); #2;
        check("rst_uart_write", 16'(uart_write), 16'd0);
        check("rst_uart_read", 16'(uart_read), 16'd0);
        check("rst_tx_data", 16'(tx_data), 16'd0);
        check("rst_irq", 16'(irq), 16'd0);
        rst_in = 1;
        cpu_read(REG_STATUS);
        cpu_read(REG_LEVEL);
        check_irq();
        foreach (hello[i]) send_rx(hello[i], 0);
        cpu_read(REG_LEVEL);
        repeat (3) cpu_read(REG_DATA);
        cpu_read(REG_STATUS);
        core_drop = 1; tx_allow = 1; last_wr = -1;
        cpu_write(REG_DATA, 16'h0055);
        cpu_write(REG_DATA, 16'h00AA);
        wait_drain();
        cpu_read(REG_STATUS);
        core_drop = 0; timeout_mode = 1; last_wr = -1;
        cpu_write(REG_DATA, 16'h0012);
        cpu_write(REG_DATA, 16'h0034);
        cpu_write(REG_DATA, 16'h0056);
        wait_drain();
        timeout_mode = 0; tx_allow = 0; core_drop = 1;
        cpu_read(REG_STATUS);
        for (int i = 0; i < 17; i++) send_rx(8'($urandom), 0);
        cpu_read(REG_LEVEL);
        cpu_read(REG_STATUS);
        check_irq();
        cpu_write(REG_STATUS, 16'h0010);
        cpu_read(REG_STATUS);
        send_rx(8'($urandom), 1);
        cpu_read(REG_LEVEL);
        cpu_read(REG_STATUS);
        repeat (16) cpu_read(REG_DATA);
        cpu_read(REG_STATUS);
        cpu_write(REG_CTRL, 16'h0001);
        check_irq();
        @(posedge cpu_clk); #2;
        rx_data = 8'h5A; rx_new = 1; rx_m.push_back(8'h5A);
        @(posedge cpu_clk); #2;
        check("irq_push_uart_read", 16'(uart_read), 16'd1);
        check("irq_not_yet", 16'(irq), 16'd0);
        rx_new = 0;
        @(posedge cpu_clk); #2;
        check("irq_rise", 16'(irq), 16'd1);
        cpu_read(REG_DATA);
        check("irq_before_fall", 16'(irq), 16'd1);
        @(posedge cpu_clk); #2;
        check("irq_fall", 16'(irq), 16'd0);
        cpu_write(REG_CTRL, 16'h0000);
        send_rx(8'h77, 0);
        cpu_write(REG_DATA, 16'h0011);
        cpu_write(REG_DATA, 16'h0022);
        @(posedge cpu_clk); #2;
        addr = REG_STATUS; tx_allow = 1; core_drop = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge cpu_clk); #1;
            found = uart_write;
        end
        check("pulse_found", 16'(found), 16'd1);
        rst_in = 0;
        #1;
        check("rst_mid_uart_write", 16'(uart_write), 16'd0);
        check("rst_mid_status", rdata, 16'h0005);
        check("rst_mid_tx_data", 16'(tx_data), 16'd0);
        check("rst_mid_irq", 16'(irq), 16'd0);
        addr = REG_LEVEL;
        #1;
        check("rst_mid_level", rdata, 16'h0000);
        rx_m.delete(); tx_m.delete(); rd_exp.delete();
        ovf_m = 0; ctrl_m = 0; tx_allow = 0; last_wr = -1;
        @(posedge cpu_clk); #2;
        rst_in = 1;
        repeat (150) begin
            case ($urandom_range(0, 7))
                0, 1, 2: send_rx(8'($urandom), 0);
                3:       cpu_read(REG_DATA);
                4:       cpu_write(REG_DATA, 16'($urandom));
                5:       cpu_read(2'($urandom_range(1, 3)));
                6:       cpu_write(2'($urandom_range(1, 2)), 16'($urandom));
                default: check_irq();
            endcase
        end
        cpu_read(REG_STATUS);
        check_irq();
        tx_allow = 1; core_drop = 1; last_wr = -1;
        wait_drain();
        cpu_read(REG_STATUS);
        cpu_read(REG_LEVEL);
        while (rx_m.size() > 0) cpu_read(REG_DATA);
        cpu_read(REG_STATUS);
        repeat (3) @(posedge cpu_clk);
        check("rd_exp_pending", 16'(rd_exp.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
